// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: NOP word, opcodes and fetch FSM states.
// Imported by the fetch stage and by the decoder/controller.
package mips_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/pc_register.sv
// Program counter with next-PC selection.
// Priority: reset, then branch redirect, then stall, then sequential PC+4.
module pc_register
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Stall,
    input  logic        PCSrc,
    input  logic [31:0] BranchTarget,
    output logic [31:0] PC,
    output logic [31:0] PCNextSeq
);

    // Low target bits are dropped so the PC stays word aligned.
    logic unused_target_bits;
    assign unused_target_bits = ^BranchTarget[1:0];

    // Sequential successor; wraps modulo 2^32.
    always_comb begin
        PCNextSeq = PC + 32'd4;
    end

    // PC update: redirect wins over stall, stall holds.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            PC <= {RESET_PC[31:2], 2'b00};
        end else if (PCSrc) begin
            PC <= {BranchTarget[31:2], 2'b00};
        end else if (!Stall) begin
            PC <= PCNextSeq;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC, imem address, IF/ID register and flush FSM.
// Define FETCH_STATS_EN to add FetchCount/StallCount statistics outputs.
module instruction_fetch
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IMEM_AW  = 10
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               Stall,
    input  logic               PCSrc,
    input  logic [31:0]        BranchTarget,
    output logic [IMEM_AW-1:0] InstrAddr,
    input  logic [31:0]        InstrData,
    output logic [31:0]        PC,
    output logic [31:0]        Instruction,
    output logic [31:0]        PCPlus4,
`ifdef FETCH_STATS_EN
    output logic [31:0]        FetchCount,
    output logic [31:0]        StallCount,
`endif
    output logic               Valid
);

    logic [31:0]  pc_next_seq;
    fetch_state_t state;
    fetch_state_t state_next;
    logic         fetch_en;

    pc_register #(
        .RESET_PC     (RESET_PC)
    ) u_pc (
        .Clk          (Clk),
        .Rst          (Rst),
        .Stall        (Stall),
        .PCSrc        (PCSrc),
        .BranchTarget (BranchTarget),
        .PC           (PC),
        .PCNextSeq    (pc_next_seq)
    );

    // Word address into imem; upper PC bits alias silently.
    always_comb begin
        InstrAddr = PC[IMEM_AW+1:2];
    end

    assign fetch_en = !PCSrc && !Stall;

    // IF/ID register: flush to NOP on redirect, hold on stall.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            Instruction <= NOP_INSTR;
            PCPlus4     <= 32'd0;
        end else if (PCSrc) begin
            Instruction <= NOP_INSTR;
            PCPlus4     <= 32'd0;
        end else if (!Stall) begin
            Instruction <= InstrData;
            PCPlus4     <= pc_next_seq;
        end
    end

    // State register; reset parks in FLUSH so the entry starts invalid.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= FLUSH;
        end else begin
            state <= state_next;
        end
    end

    // Next state and valid: any redirect flushes, a clean fetch runs.
    always_comb begin
        state_next = state;
        Valid      = 1'b0;
        unique case (state)
            RUN: begin
                Valid = 1'b1;
                if (PCSrc) begin
                    state_next = FLUSH;
                end
            end
            FLUSH: begin
                Valid = 1'b0;
                if (PCSrc) begin
                    state_next = FLUSH;
                end else if (!Stall) begin
                    state_next = RUN;
                end
            end
            default: begin
                state_next = FLUSH;
            end
        endcase
    end

`ifdef FETCH_STATS_EN
    // Statistics: count fetch and stall edges, wrapping.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            FetchCount <= 32'd0;
            StallCount <= 32'd0;
        end else begin
            if (fetch_en) begin
                FetchCount <= FetchCount + 32'd1;
            end
            if (Stall && !PCSrc) begin
                StallCount <= StallCount + 32'd1;
            end
        end
    end
`else
    logic unused_fetch_en;
    assign unused_fetch_en = fetch_en;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Randomized + directed bench for instruction_fetch against a
// cycle-level behavioural model of the fetch rules.
module tb_instruction_fetch;

    localparam int AW = 10;

    logic          Clk;
    logic          Rst;
    logic          Stall;
    logic          PCSrc;
    logic [31:0]   BranchTarget;
    logic [AW-1:0] InstrAddr;
    logic [31:0]   InstrData;
    logic [31:0]   PC;
    logic [31:0]   Instruction;
    logic [31:0]   PCPlus4;
    logic          Valid;
`ifdef FETCH_STATS_EN
    logic [31:0]   FetchCount;
    logic [31:0]   StallCount;
`endif

    logic [31:0] imem [0:(1<<AW)-1];

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_pcp4;
    logic        m_valid;
    logic [31:0] m_fetch;
    logic [31:0] m_stall;

    instruction_fetch #(
        .RESET_PC     (32'h0000_0000),
        .IMEM_AW      (AW)
    ) dut (
        .Clk          (Clk),
        .Rst          (Rst),
        .Stall        (Stall),
        .PCSrc        (PCSrc),
        .BranchTarget (BranchTarget),
        .InstrAddr    (InstrAddr),
        .InstrData    (InstrData),
        .PC           (PC),
        .Instruction  (Instruction),
        .PCPlus4      (PCPlus4),
`ifdef FETCH_STATS_EN
        .FetchCount   (FetchCount),
        .StallCount   (StallCount),
`endif
        .Valid        (Valid)
    );

    assign InstrData = imem[InstrAddr];

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        check("pc", PC, m_pc);
        check("addr", {22'd0, InstrAddr}, {22'd0, m_pc[AW+1:2]});
        check("instr", Instruction, m_instr);
        check("pcp4", PCPlus4, m_pcp4);
        check("valid", {31'd0, Valid}, {31'd0, m_valid});
`ifdef FETCH_STATS_EN
        check("fcnt", FetchCount, m_fetch);
        check("scnt", StallCount, m_stall);
`endif
    endtask

    // One clock edge: drive, update model from the rules, compare.
    task automatic step(input logic r, input logic s, input logic p,
                        input logic [31:0] bt);
        Rst          = r;
        Stall        = s;
        PCSrc        = p;
        BranchTarget = bt;
        @(posedge Clk);
        if (r) begin
            m_pc    = 32'h0;
            m_instr = 32'h0;
            m_pcp4  = 32'h0;
            m_valid = 1'b0;
            m_fetch = 32'h0;
            m_stall = 32'h0;
        end else if (p) begin
            m_pc    = bt & 32'hFFFF_FFFC;
            m_instr = 32'h0;
            m_pcp4  = 32'h0;
            m_valid = 1'b0;
        end else if (s) begin
            m_stall = m_stall + 1;
        end else begin
            m_instr = imem[m_pc[AW+1:2]];
            m_pc    = m_pc + 32'd4;
            m_pcp4  = m_pc;
            m_valid = 1'b1;
            m_fetch = m_fetch + 1;
        end
        #1;
        check_all();
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) imem[i] = $urandom;
        m_pc = 0; m_instr = 0; m_pcp4 = 0; m_valid = 0;
        m_fetch = 0; m_stall = 0;
        Rst = 1; Stall = 0; PCSrc = 0; BranchTarget = 0;

        // Reset held two cycles
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        check("rst_pc", PC, 32'h0);
        // First fetches
        step(0, 0, 0, 0);
        check("f0_instr", Instruction, imem[0]);
        check("f0_pcp4", PCPlus4, 32'd4);
        step(0, 0, 0, 0);
        check("f1_instr", Instruction, imem[1]);
        check("f1_pcp4", PCPlus4, 32'd8);
        step(0, 0, 0, 0);
        // Stall three cycles on imem[2]
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 0);
            check("stall_hold", Instruction, imem[2]);
        end
        step(0, 0, 0, 0);
        check("after_stall", Instruction, imem[3]);
        // Redirect to 0x40
        step(0, 0, 1, 32'h40);
        check("redir_pc", PC, 32'h40);
        check("redir_v", {31'd0, Valid}, 32'd0);
        step(0, 0, 0, 0);
        check("redir_tgt", Instruction, imem[16]);
        check("redir_v1", {31'd0, Valid}, 32'd1);
        // Redirect while stalled, misaligned target
        step(0, 1, 1, 32'h23);
        check("rs_pc", PC, 32'h20);
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        check("rs_instr", Instruction, imem[8]);
        // Back-to-back redirect stays flushed
        step(0, 0, 1, 32'h100);
        step(0, 0, 1, 32'h200);
        check("bb_pc", PC, 32'h200);
        // Wrap at top of address space
        step(0, 0, 1, 32'hFFFF_FFFC);
        check("wrap_addr", {22'd0, InstrAddr}, 32'd1023);
        step(0, 0, 0, 0);
        check("wrap_pc", PC, 32'h0);
        check("wrap_pcp4", PCPlus4, 32'h0);
        check("wrap_instr", Instruction, imem[1023]);

`ifdef FETCH_STATS_EN
        // Stats: 5 fetches, 2 stalls, 1 redirect after reset
        step(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        step(0, 0, 1, 32'h80);
        check("stat_fetch", FetchCount, 32'd5);
        check("stat_stall", StallCount, 32'd2);
`endif

        // Randomized phase
        for (int i = 0; i < 500; i++) begin
            step($urandom_range(0, 59) == 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 7) == 0,
                 $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
